cal_denorm: RTL and testbench

//   Inverse of the current normalisation n = curr - floor(curr/per): recovers a raw

---
 rtl/cal_denorm.sv | 151 +++++++++++++++
 tb/tb_cal_denorm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cal_denorm.sv
// Recovers a raw current c = floor(n*per/(per-1)) from a normalised current using a
// one-cycle multiply and a shared restoring divider. Optional forward check: CAL_DENORM_CHECK_EN.
module cal_denorm #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] curr_norm,
  input  logic [W-1:0] per,
  output logic [W-1:0] curr,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         mismatch
);

  localparam int CW = $clog2(2 * W) + 1;

  typedef enum logic [2:0] {IDLE, MUL, DIV, CHK, FIN} state_t;

  state_t         state;
  logic [W-1:0]   n_q;
  logic [W-1:0]   p_q;
  logic [W-1:0]   d_q;
  logic [2*W-1:0] acc;
  logic [W-1:0]   rem;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   c_q;
  logic           err_q;
`ifdef CAL_DENORM_CHECK_EN
  logic           mis_q;
`endif

  // One restoring step: the quotient bit shifts into acc's LSB as the dividend leaves its MSB.
  // The partial remainder stays below twice the divisor, so the borrow alone decides the bit.
  logic [W:0]     prem;
  logic [W:0]     diff;
  logic           qbit;
  logic [W-1:0]   rem_nx;
  logic [2*W-1:0] acc_nx;

  assign prem   = {rem, acc[2*W-1]};
  assign diff   = prem - {1'b0, d_q};
  assign qbit   = ~diff[W];
  assign rem_nx = qbit ? diff[W-1:0] : prem[W-1:0];
  assign acc_nx = {acc[2*W-2:0], qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      n_q   <= '0;
      p_q   <= '0;
      d_q   <= '0;
      acc   <= '0;
      rem   <= '0;
      cnt   <= '0;
      c_q   <= '0;
      err_q <= 1'b0;
      curr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef CAL_DENORM_CHECK_EN
      mis_q    <= 1'b0;
      mismatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go && !done) begin
            n_q  <= curr_norm;
            p_q  <= per;
            busy <= 1'b1;
`ifdef CAL_DENORM_CHECK_EN
            mis_q <= 1'b0;
`endif
            if (per < W'(2)) begin
              err_q <= 1'b1;
              c_q   <= curr_norm;
              state <= FIN;
            end else begin
              err_q <= 1'b0;
              state <= MUL;
            end
          end
        end
        MUL: begin
          acc   <= {{W{1'b0}}, n_q} * {{W{1'b0}}, p_q};
          d_q   <= p_q - W'(1);
          rem   <= '0;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          acc <= acc_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(2 * W - 1)) begin
            if (acc_nx[2*W-1:W] != '0) begin
              err_q <= 1'b1;
              c_q   <= '1;
              state <= FIN;
            end else begin
              c_q <= acc_nx[W-1:0];
`ifdef CAL_DENORM_CHECK_EN
              // Reload the divider with c in the upper half to compute c/per next.
              acc   <= {acc_nx[W-1:0], {W{1'b0}}};
              rem   <= '0;
              d_q   <= p_q;
              cnt   <= '0;
              state <= CHK;
`else
              state <= FIN;
`endif
            end
          end
        end
`ifdef CAL_DENORM_CHECK_EN
        CHK: begin
          if (cnt < CW'(W)) begin
            acc <= acc_nx;
            rem <= rem_nx;
            cnt <= cnt + CW'(1);
          end else begin
            mis_q <= (c_q - acc[W-1:0]) != n_q;
            state <= FIN;
          end
        end
`endif
        FIN: begin
          curr  <= c_q;
          err   <= err_q;
          done  <= 1'b1;
          busy  <= 1'b0;
`ifdef CAL_DENORM_CHECK_EN
          mismatch <= mis_q;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CAL_DENORM_CHECK_EN
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cal_denorm.sv
// Randomised bench for cal_denorm: a scoreboard predicts done timing, busy, curr and err
// from the arithmetic definition and one process compares the DUT against it every cycle.
module tb_cal_denorm;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go = 1'b0;
  logic [W-1:0] curr_norm = '0;
  logic [W-1:0] per = '0;
  logic [W-1:0] curr;
  logic         busy;
  logic         done;
  logic         err;
  logic         mismatch;

  cal_denorm #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .curr_norm(curr_norm),
    .per      (per),
    .curr     (curr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges++;

  int compared = 0;
  int failed = 0;

  // Scoreboard for the one accepted operation in flight.
  bit           valid = 1'b0;
  int           kS = 0;
  int           dueS = 0;
  logic [W-1:0] pendCurr = '0;
  logic [W-1:0] pendN = '0;
  logic [W-1:0] pendPer = '0;
  logic         pendErr = 1'b0;
  logic [W-1:0] expCurr = '0;
  logic         expErr = 1'b0;

  function automatic void refModel(input logic [W-1:0] n, input logic [W-1:0] p,
                                   output logic [W-1:0] c, output logic e, output int lat);
    longint unsigned nn, pp, q;
    nn = n;
    pp = p;
    if (pp < 2) begin
      c   = n;
      e   = 1'b1;
      lat = 1;
    end else begin
      q = (nn * pp) / (pp - 1);
      if (q > ((longint'(1) << W) - 1)) begin
        c = '1;
        e = 1'b1;
      end else begin
        c = q[W-1:0];
        e = 1'b0;
      end
`ifdef CAL_DENORM_CHECK_EN
      lat = e ? 2 * W + 2 : 3 * W + 3;
`else
      lat = 2 * W + 2;
`endif
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edges);
    end
  endtask

  always @(negedge clk) begin : compareProc
    bit eDone, eBusy;
    if (rst) begin
      checkOutput("rst_curr", 64'(curr), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_mismatch", 64'(mismatch), 64'd0);
    end else begin
      eDone = valid && (edges == dueS);
      eBusy = valid && (edges >= kS) && (edges < dueS);
      if (eDone) begin
        expCurr = pendCurr;
        expErr  = pendErr;
      end
      checkOutput("done", 64'(done), 64'(eDone));
      checkOutput("busy", 64'(busy), 64'(eBusy));
      checkOutput("curr", 64'(curr), 64'(expCurr));
      checkOutput("err", 64'(err), 64'(expErr));
      checkOutput("mismatch", 64'(mismatch), 64'd0);
      if (eDone && !pendErr)
        checkOutput("preimage", 64'(curr) - 64'(curr) / 64'(pendPer), 64'(pendN));
    end
  end

  task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] p);
    int k, lat;
    logic [W-1:0] c;
    logic e;
    @(posedge clk);
    #1;
    curr_norm = n;
    per = p;
    go = 1'b1;
    k = edges + 1;
    if (!rst && (!valid || k >= dueS + 2)) begin
      refModel(n, p, c, e, lat);
      valid    = 1'b1;
      kS       = k;
      dueS     = k + lat;
      pendCurr = c;
      pendErr  = e;
      pendN    = n;
      pendPer  = p;
    end
    @(posedge clk);
    #1;
    go = 1'b0;
    curr_norm = W'($urandom);
    per = W'($urandom);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 200 && valid && edges <= dueS; i++) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid = 1'b0;
    expCurr = '0;
    expErr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pinModel(input logic [W-1:0] n, input logic [W-1:0] p,
                          input logic [W-1:0] c, input logic e, input int lat);
    logic [W-1:0] mc;
    logic me;
    int ml;
    refModel(n, p, mc, me, ml);
    checkOutput("model_curr", 64'(mc), 64'(c));
    checkOutput("model_err", 64'(me), 64'(e));
    checkOutput("model_lat", 64'(ml), 64'(lat));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, edge %0d", edges);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int longLat;
`ifdef CAL_DENORM_CHECK_EN
    longLat = 51;
`else
    longLat = 34;
`endif
    pinModel(16'd8, 16'd4, 16'd10, 1'b0, longLat);
    pinModel(16'd9, 16'd4, 16'd12, 1'b0, longLat);
    pinModel(16'd5, 16'd1, 16'd5, 1'b1, 1);
    pinModel(16'hFFFF, 16'd2, 16'hFFFF, 1'b1, 34);
    pinModel(16'hFFFE, 16'hFFFF, 16'hFFFF, 1'b0, longLat);
    pinModel(16'd0, 16'd3, 16'd0, 1'b0, longLat);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(16'd8, 16'd4);      waitDone();
    applyStimulus(16'd9, 16'd4);      waitDone();
    applyStimulus(16'd5, 16'd1);      waitDone();
    applyStimulus(16'd5, 16'd0);      waitDone();
    applyStimulus(16'hFFFF, 16'd2);   waitDone();
    applyStimulus(16'hFFFE, 16'hFFFF); waitDone();

    // go pulses while busy, then an abort by reset mid-operation
    applyStimulus(16'd100, 16'd7);
    repeat (3) applyStimulus(W'($urandom), W'($urandom));
    repeat (2) @(posedge clk);
    doReset();
    repeat (40) @(posedge clk);
    applyStimulus(16'd0, 16'd3);      waitDone();

    // back-to-back go right at the done cycle
    applyStimulus(16'd20, 16'd5);
    for (int i = 0; i < 200 && edges < dueS; i++) @(posedge clk);
    applyStimulus(16'd21, 16'd5);
    applyStimulus(16'd22, 16'd5);     waitDone();

    for (int it = 0; it < 300; it++) begin
      logic [W-1:0] n, p;
      n = W'($urandom);
      case ($urandom_range(0, 3))
        0: p = W'($urandom_range(0, 5));
        1: p = W'($urandom_range(65530, 65535));
        default: p = W'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) n = W'($urandom_range(0, 3));
      applyStimulus(n, p);
      repeat ($urandom_range(0, 60)) @(posedge clk);
      if ($urandom_range(0, 40) == 0) doReset();
    end
    waitDone();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
